// File: rtl/hazard_ctrl.sv
// Central hazard unit beside the ID stage: load-use stalls, taken-branch redirects and
// fixed-latency multi-cycle EX freezes, plus saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             uses_rs1_ID,
    input  logic             uses_rs2_ID,
    input  logic [4:0]       rd_EX,
    input  logic             MemRead_EX,
    input  logic             long_op_EX,
    input  logic             branch_taken_EX,
    input  logic [31:0]      branch_target_EX,
    input  logic             clr_cnt,
    output logic             PCWrite,
    output logic             Write_IFID,
    output logic             flush_IF,
    output logic             Write_IDEX,
    output logic             flush_IDEX,
    output logic             PCSrc_IF,
    output logic [31:0]      PCTarget_IF,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // cnt only ever holds LONG_LAT-2 down to 0; keep at least one bit for LONG_LAT == 2.
    localparam int              CW       = (LONG_LAT > 2) ? $clog2(LONG_LAT - 1) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(LONG_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LONG = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    assign rs1_hit  = uses_rs1_ID && (rs1_ID == rd_EX);
    assign rs2_hit  = uses_rs2_ID && (rs2_ID == rd_EX);
    assign load_use = MemRead_EX && (rd_EX != 5'd0) && (rs1_hit || rs2_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values in the same step.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                // A redirect kills the long op in EX, so only an unredirected one freezes.
                if (!branch_taken_EX && long_op_EX) begin
                    state_d = ST_LONG;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_LONG: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        // NOTE: every output is given its default before any branch, so none infers a latch.
        PCWrite     = 1'b1;
        Write_IFID  = 1'b1;
        Write_IDEX  = 1'b1;
        flush_IF    = 1'b0;
        flush_IDEX  = 1'b0;
        PCSrc_IF    = 1'b0;
        PCTarget_IF = 32'b0;
        case (state_q)
            ST_RUN: begin
                if (branch_taken_EX) begin
                    PCSrc_IF    = 1'b1;
                    PCTarget_IF = branch_target_EX;
                    flush_IF    = 1'b1;
                    flush_IDEX  = 1'b1;
                end else if (long_op_EX) begin
                    PCWrite    = 1'b0;
                    Write_IFID = 1'b0;
                    Write_IDEX = 1'b0;
                end else if (load_use) begin
                    PCWrite    = 1'b0;
                    Write_IFID = 1'b0;
                    flush_IDEX = 1'b1;
                end
            end
            ST_LONG: begin
                // cnt == 0 is the release cycle: EX hands over, defaults regardless of inputs.
                if (cnt_q != '0) begin
                    PCWrite    = 1'b0;
                    Write_IFID = 1'b0;
                    Write_IDEX = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!PCWrite && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (PCSrc_IF && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a cycle-age model checked every negedge against a 32-bit and a
// 4-bit counter instance, plus directed scenarios with hand-computed literal values.
module tb_hazard_ctrl;

    localparam int LONG_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
    logic        uses_rs1_ID = 1'b0, uses_rs2_ID = 1'b0;
    logic        MemRead_EX = 1'b0, long_op_EX = 1'b0, branch_taken_EX = 1'b0;
    logic [31:0] branch_target_EX = '0;
    logic        clr_cnt = 1'b0;

    logic        PCWrite, Write_IFID, flush_IF, Write_IDEX, flush_IDEX, PCSrc_IF;
    logic [31:0] PCTarget_IF;
    logic [31:0] stall_cnt, flush_cnt;
    logic        PCWrite_4, Write_IFID_4, flush_IF_4, Write_IDEX_4, flush_IDEX_4, PCSrc_IF_4;
    logic [31:0] PCTarget_IF_4;
    logic [3:0]  stall_cnt_4, flush_cnt_4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LONG_LAT(LONG_LAT), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
        .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .long_op_EX(long_op_EX),
        .branch_taken_EX(branch_taken_EX), .branch_target_EX(branch_target_EX),
        .clr_cnt(clr_cnt),
        .PCWrite(PCWrite), .Write_IFID(Write_IFID), .flush_IF(flush_IF),
        .Write_IDEX(Write_IDEX), .flush_IDEX(flush_IDEX), .PCSrc_IF(PCSrc_IF),
        .PCTarget_IF(PCTarget_IF), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.LONG_LAT(LONG_LAT), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
        .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .long_op_EX(long_op_EX),
        .branch_taken_EX(branch_taken_EX), .branch_target_EX(branch_target_EX),
        .clr_cnt(clr_cnt),
        .PCWrite(PCWrite_4), .Write_IFID(Write_IFID_4), .flush_IF(flush_IF_4),
        .Write_IDEX(Write_IDEX_4), .flush_IDEX(flush_IDEX_4), .PCSrc_IF(PCSrc_IF_4),
        .PCTarget_IF(PCTarget_IF_4), .stall_cnt(stall_cnt_4), .flush_cnt(flush_cnt_4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        pc_write;
        logic        write_ifid;
        logic        write_idex;
        logic        flush_if;
        logic        flush_idex;
        logic        pc_src;
        logic [31:0] target;
    } ctl_t;

    int     cyc        = 0;
    int     long_start = -1;  // cycle number of the long-op issue, -1 when none pending
    longint n_stall    = 0;
    longint n_flush    = 0;

    function automatic longint sat(input longint n, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (n > m) ? m : n;
    endfunction

    function automatic int age();
        return (long_start >= 0) ? (cyc - long_start) : -1;
    endfunction

    function automatic ctl_t model_ctl();
        ctl_t c;
        logic lu;
        int   a;
        c  = '{pc_write: 1'b1, write_ifid: 1'b1, write_idex: 1'b1, flush_if: 1'b0,
               flush_idex: 1'b0, pc_src: 1'b0, target: 32'h0};
        lu = MemRead_EX && rd_EX != 0 &&
             ((uses_rs1_ID && rs1_ID == rd_EX) || (uses_rs2_ID && rs2_ID == rd_EX));
        a  = age();
        if (a >= 1 && a <= LONG_LAT - 2) begin
            c.pc_write = 0; c.write_ifid = 0; c.write_idex = 0;
        end else if (a == LONG_LAT - 1) begin
            // release cycle: defaults whatever the inputs
        end else if (branch_taken_EX) begin
            c.pc_src = 1; c.target = branch_target_EX; c.flush_if = 1; c.flush_idex = 1;
        end else if (long_op_EX) begin
            c.pc_write = 0; c.write_ifid = 0; c.write_idex = 0;
        end else if (lu) begin
            c.pc_write = 0; c.write_ifid = 0; c.flush_idex = 1;
        end
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_start <= -1;
            n_stall    <= 0;
            n_flush    <= 0;
        end else begin
            ctl_t c;
            int   a;
            assert (!(long_op_EX && branch_taken_EX))
                else $error("illegal long_op_EX with branch_taken_EX in stimulus");
            c = model_ctl();
            a = age();
            if (clr_cnt) begin
                n_stall <= 0;
                n_flush <= 0;
            end else begin
                n_stall <= n_stall + (c.pc_write ? 0 : 1);
                n_flush <= n_flush + (c.pc_src ? 1 : 0);
            end
            if (a == LONG_LAT - 1)
                long_start <= -1;
            else if (a < 1 && !branch_taken_EX && long_op_EX)
                long_start <= cyc;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ctl_t e;
        e = model_ctl();
        check("cmp PCWrite",     PCWrite,     e.pc_write);
        check("cmp Write_IFID",  Write_IFID,  e.write_ifid);
        check("cmp Write_IDEX",  Write_IDEX,  e.write_idex);
        check("cmp flush_IF",    flush_IF,    e.flush_if);
        check("cmp flush_IDEX",  flush_IDEX,  e.flush_idex);
        check("cmp PCSrc_IF",    PCSrc_IF,    e.pc_src);
        check("cmp PCTarget_IF", PCTarget_IF, e.target);
        check("cmp ctl4", {PCWrite_4, Write_IFID_4, Write_IDEX_4, flush_IF_4, flush_IDEX_4,
                           PCSrc_IF_4, PCTarget_IF_4}, e);
        check("cmp stall_cnt",   stall_cnt,   sat(n_stall, 32));
        check("cmp flush_cnt",   flush_cnt,   sat(n_flush, 32));
        check("cmp stall_cnt4",  stall_cnt_4, sat(n_stall, 4));
        check("cmp flush_cnt4",  flush_cnt_4, sat(n_flush, 4));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_ID = 0; rs2_ID = 0; rd_EX = 0; uses_rs1_ID = 0; uses_rs2_ID = 0;
        MemRead_EX = 0; long_op_EX = 0; branch_taken_EX = 0; branch_target_EX = 32'hdead_beef;
        clr_cnt = 0;
    endtask

    task automatic set_load_use();
        MemRead_EX = 1; rd_EX = 5; rs1_ID = 5; uses_rs1_ID = 1;
    endtask

    task automatic check_ctl(input string name, input logic [5:0] exp);
        check(name, {PCWrite, Write_IFID, Write_IDEX, flush_IF, flush_IDEX, PCSrc_IF}, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        tick();
        // reset state: defaults, counters zero
        check_ctl("reset ctl", 6'b111000);
        check("reset target", PCTarget_IF, 32'h0);
        check("reset stall", stall_cnt, 0);
        check("reset flush", flush_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // 1: load-use stall for one cycle
        set_load_use();
        #1;
        check_ctl("lu ctl", 6'b001010);
        check("lu stall before", stall_cnt, 0);
        tick();
        idle();
        #1;
        check("lu stall after", stall_cnt, 1);
        check_ctl("lu next ctl", 6'b111000);

        // 2: x0 destination and unused operand never stall
        MemRead_EX = 1; rd_EX = 0; rs1_ID = 0; uses_rs1_ID = 1;
        #1;
        check_ctl("x0 ctl", 6'b111000);
        tick();
        rd_EX = 5; rs1_ID = 5; rs2_ID = 5; uses_rs1_ID = 0; uses_rs2_ID = 0;
        #1;
        check_ctl("unused ctl", 6'b111000);
        check("unused target", PCTarget_IF, 32'h0);
        tick();
        uses_rs2_ID = 1;
        #1;
        check_ctl("rs2 lu ctl", 6'b001010);
        tick();
        idle();
        #1;
        check("rs2 lu stall", stall_cnt, 2);

        // 3: redirect beats a concurrent load-use
        set_load_use();
        branch_taken_EX = 1; branch_target_EX = 32'h100;
        #1;
        check_ctl("br ctl", 6'b111111);
        check("br target", PCTarget_IF, 32'h100);
        tick();
        idle();
        #1;
        check("br flush", flush_cnt, 1);
        check("br stall", stall_cnt, 2);

        // 4: long op freezes exactly LONG_LAT-1 cycles, ignoring inputs
        long_op_EX = 1;
        #1;
        check_ctl("long c0", 6'b000000);
        tick();
        long_op_EX = 0; branch_taken_EX = 1; branch_target_EX = 32'h200;
        #1;
        check_ctl("long c1 br", 6'b000000);
        check("long c1 target", PCTarget_IF, 32'h0);
        tick();
        idle();
        set_load_use();
        #1;
        check_ctl("long c2 lu", 6'b000000);
        tick();
        long_op_EX = 1;
        #1;
        check_ctl("long c3 release", 6'b111000);
        check("long c3 stall", stall_cnt, 5);
        tick();
        idle();
        #1;
        check("long after stall", stall_cnt, 5);
        check("long after flush", flush_cnt, 1);
        check_ctl("long after ctl", 6'b111000);

        // 5: reset during the second LONG cycle
        long_op_EX = 1;
        tick();
        long_op_EX = 0;
        #1;
        check_ctl("rst pre frozen", 6'b000000);
        rst_n = 0;
        #1;
        check_ctl("rst mid ctl", 6'b111000);
        check("rst mid stall", stall_cnt, 0);
        check("rst mid flush", flush_cnt, 0);
        check("rst mid stall4", stall_cnt_4, 0);
        #1;
        rst_n = 1;
        tick();
        set_load_use();
        #1;
        check_ctl("rst after run", 6'b001010);

        // 6: saturation of the 4-bit counters, then clear beats increment
        for (int i = 0; i < 20; i++) tick();
        check("sat stall4", stall_cnt_4, 15);
        check("sat stall32", stall_cnt, 20);
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        idle();
        #1;
        check("clr stall4", stall_cnt_4, 0);
        check("clr stall32", stall_cnt, 0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
